// File: rtl/bus_wrr_sched.sv
// Weighted round-robin bus scheduler: pops one packet at a time from a granted
// terminal and pushes it to the destination mask, stalling on destination full.
module bus_wrr_sched #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int          wgt_w     = 4,
  localparam int         GW        = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           full,
  input  logic [drvrs*wgt_w-1:0]     weight,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [GW-1:0]              gnt_id,
  output logic                       busy,
  output logic [7:0]                 err_cnt
);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state, state_nx;
  logic [GW-1:0]      ptr, ptr_nx, gnt_nx, sel;
  logic               sel_vld;
  logic [wgt_w-1:0]   credit, credit_nx, credit_dec, wgt_sel, wgt_load;
  logic [pckg_sz-1:0] pkt, pkt_nx, last_q;
  logic [7:0]         dest, err_nx;
  logic [drvrs-1:0]   mask, gnt_oh;
  logic               dest_ok, stall, fire;

  // First pending terminal at or above ptr, wrapping; lowest offset wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = drvrs-1; k >= 0; k--) begin
      if (pndng[(int'(ptr) + k) % drvrs]) begin
        sel     = GW'((int'(ptr) + k) % drvrs);
        sel_vld = 1'b1;
      end
    end
  end

  assign wgt_sel    = weight[int'(sel)*wgt_w +: wgt_w];
  assign wgt_load   = (wgt_sel == '0) ? wgt_w'(1) : wgt_sel;
  assign credit_dec = credit - wgt_w'(1);

  assign dest    = pkt[pckg_sz-1 -: 8];
  assign dest_ok = (dest == broadcast) || (int'(dest) < drvrs);

  for (genvar i = 0; i < drvrs; i++) begin : g_mask
    assign mask[i] = (dest == broadcast) ? (GW'(i) != gnt_id) : (dest == 8'(i));
  end

  assign gnt_oh = drvrs'(1) << gnt_id;
  assign stall  = |(mask & full);
  assign fire   = (state == PUSH) && dest_ok && !stall;
  assign pop    = (state == POP) ? gnt_oh : '0;
  assign push   = fire ? mask : '0;
  assign D_push = fire ? pkt : last_q;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx  = state;
    gnt_nx    = gnt_id;
    ptr_nx    = ptr;
    credit_nx = credit;
    pkt_nx    = pkt;
    err_nx    = err_cnt;
    case (state)
      IDLE: if (sel_vld) begin
        gnt_nx    = sel;
        credit_nx = wgt_load;
        state_nx  = POP;
      end
      POP: begin
        pkt_nx   = D_pop[int'(gnt_id)*pckg_sz +: pckg_sz];
        state_nx = PUSH;
      end
      PUSH: if (!dest_ok || !stall) begin
        // Invalid destinations drop the packet but still consume a credit.
        if (!dest_ok && err_cnt != 8'hFF) err_nx = err_cnt + 8'd1;
        credit_nx = credit_dec;
        if (credit_dec != '0 && pndng[gnt_id]) begin
          state_nx = POP;
        end else begin
          state_nx = IDLE;
          ptr_nx   = (gnt_id == GW'(drvrs-1)) ? '0 : gnt_id + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt_id  <= '0;
      ptr     <= '0;
      credit  <= '0;
      pkt     <= '0;
      last_q  <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      gnt_id  <= gnt_nx;
      ptr     <= ptr_nx;
      credit  <= credit_nx;
      pkt     <= pkt_nx;
      err_cnt <= err_nx;
      if (fire) last_q <= pkt;
    end
  end

endmodule

// File: doc/bus_wrr_sched.md
BUS_WRR_SCHED -- requirements
Module: bus_wrr_sched

Interface
REQ-001 Parameter drvrs, default 4, number of bus terminals (requesters and destinations).
REQ-002 Parameter pckg_sz, default 16, packet width in bits.
REQ-003 Parameter broadcast, default 8'hFF, destination ID meaning all terminals.
REQ-004 Parameter wgt_w, default 4, per-terminal weight field width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 pndng  in  drvrs  terminal i FIFO non-empty (first-word-fall-through).
REQ-008 D_pop  in  drvrs*pckg_sz  head packet of terminal i at slice [i*pckg_sz +: pckg_sz].
REQ-009 full  in  drvrs  terminal i cannot accept a push this cycle.
REQ-010 weight  in  drvrs*wgt_w  packets terminal i may send per turn; 0 treated as 1.
REQ-011 pop  out  drvrs  one-hot, one-cycle dequeue strobe to granted terminal.
REQ-012 push  out  drvrs  destination mask, one-cycle enqueue strobe.
REQ-013 D_push  out  pckg_sz  packet driven to destinations, valid when push != 0.
REQ-014 gnt_id  out  $clog2(drvrs)  terminal currently granted.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err_cnt  out  8  count of dropped packets, saturating at 255.

Function
REQ-017 FSM states IDLE, POP, PUSH; one packet handled per POP->PUSH pass.
REQ-018 IDLE: if pndng != 0, select first i with pndng[i]=1 searching upward (mod drvrs) from ptr; latch i into gnt_id; go POP; else stay.
REQ-019 POP: assert pop[gnt_id] for exactly one cycle; capture D_pop slice of gnt_id into packet register; go PUSH.
REQ-020 Destination field dest = packet[pckg_sz-1 -: 8].
REQ-021 Target mask: dest==broadcast -> all ones except bit gnt_id; dest<drvrs -> one-hot bit dest (self-send allowed); otherwise invalid.
REQ-022 PUSH, valid dest: stall while (mask & full) != 0; when clear, assert push=mask and D_push=packet for one cycle.
REQ-023 PUSH, invalid dest: no push; err_cnt increments by 1 unless at 255; packet is discarded.
REQ-024 On leaving PUSH, decrement credit of gnt_id; credit loaded from weight[gnt_id] (0->1) at first grant of each turn.
REQ-025 Turn continues (next state POP, same gnt_id) when credit after decrement > 0 and pndng[gnt_id]=1; otherwise ptr <= gnt_id+1 mod drvrs, next state IDLE.
REQ-026 Latency: pndng sampled in IDLE at cycle N -> pop at N+1 -> push earliest at N+2; back-to-back burst yields one packet per 2 cycles.
REQ-027 pop and push are never asserted in the same cycle; at most one pop bit is set.
REQ-028 pndng of non-granted terminals is ignored until IDLE; pndng[gnt_id] dropping during PUSH does not abort the pending push.
REQ-029 D_push holds last pushed packet when push=0.

Reset
REQ-030 On reset: state IDLE, pop=0, push=0, D_push=0, gnt_id=0, busy=0, err_cnt=0, ptr=0, credits=0, packet register=0.
REQ-031 Reset asserted mid-POP or mid-PUSH abandons the packet; no pop or push pulse after reset assertion.

Verification
REQ-032 Single packet: pndng=0001, D_pop[0]=16'h0255 -> pop=0001 at N+1, push=0100 with D_push=16'h0255 at N+2.
REQ-033 Broadcast: terminal 1 sends 16'hFF3C, full=0 -> push=1101, D_push=16'hFF3C, one cycle.
REQ-034 Backpressure: terminal 0 sends to dest 3 with full[3]=1 for 5 cycles -> push stays 0 for 5 cycles, push=1000 on the cycle after full[3] falls.
REQ-035 Weighted round-robin: all pndng held high, weight={1,1,1,3} (terminal 0 weight 3) -> pop order 0,0,0,1,2,3,0,0,0.
REQ-036 Invalid dest: packet 16'h0711 with drvrs=4 -> pop occurs, push stays 0, err_cnt 0->1; 256 such drops -> err_cnt=255.
REQ-037 Reset during PUSH stall (full high) -> all outputs zero immediately, after release with pndng=0 busy stays 0.
